// File: rtl/seq_serializer.sv
// Parallel-to-serial framer feeding a downstream bit-serial detector, MSB first.
// Latency: word accepted at edge E drives its MSB on x after edge E+1; all outputs registered.
// Backpressure: one-word holding register; in_ready low while it is full, so offered words simply wait.
// Optional feature: define SER_PARITY_EN to append an even-parity bit (frame becomes WIDTH+1 bits).
module seq_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    // Registered outputs; their next values are decoded from the next state
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             in_ready_q, in_ready_d;

    logic             accept;
    logic             load;

    // A word is taken only when the registered ready says holding is empty.
    // Ready is low for the first cycle after reset, so no word is lost there.
    assign accept = in_valid & in_ready_q;

    // Next-state logic: frame sequencing, holding-to-shift transfer and acceptance
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif
        load        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
`ifdef SER_PARITY_EN
                    state_d = ST_PARITY;
`else
                    // Last data bit: chain straight into a waiting word, no gap
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
`ifdef SER_PARITY_EN
            ST_PARITY: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame start: move the held word into the shifter and free holding
        if (load) begin
            state_d     = ST_SHIFT;
            shift_d     = hold_q;
            cnt_d       = CNT_LAST;
            hold_full_d = 1'b0;
`ifdef SER_PARITY_EN
            par_d       = ^hold_q;
`endif
        end

        // Accept needs holding empty and load needs it full, so they never
        // collide on the same edge.
        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end
    end

    // Output decode from next state so every output comes straight off a flop
    always_comb begin
        x_d          = IDLE_VAL;
        x_valid_d    = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = (state_d != ST_IDLE) || hold_full_d;
        in_ready_d   = ~hold_full_d;

        case (state_d)
            ST_SHIFT: begin
                x_d       = shift_d[WIDTH-1];
                x_valid_d = 1'b1;
`ifndef SER_PARITY_EN
                frame_done_d = (cnt_d == '0);
`endif
            end
`ifdef SER_PARITY_EN
            ST_PARITY: begin
                x_d          = par_d;
                x_valid_d    = 1'b1;
                frame_done_d = 1'b1;
            end
`endif
            default: begin
                x_d       = IDLE_VAL;
                x_valid_d = 1'b0;
            end
        endcase
    end

    // Control and datapath state; reset aborts any frame and drops the held word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // Output registers; in_ready stays low during reset and rises on the first edge after
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q          <= IDLE_VAL;
            x_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            x_q          <= x_d;
            x_valid_q    <= x_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign in_ready   = in_ready_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: directed spec vectors plus randomized traffic.
// Reference is a queue of pending frame bits; every cycle's outputs are compared to it.
// Honours SER_PARITY_EN when defined, matching the design build.
module tb_seq_serializer;

    localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             frame_done;

    seq_serializer #(.WIDTH(WIDTH), .IDLE_VAL(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: queue of bits still to appear on x; head = bit shown now
    bit               q_bit[$];
    bit               q_done[$];
    bit               hold_full_m;
    logic [WIDTH-1:0] hold_m;
    bit               ready_m;
    bit               acc_m;
    int               cyc = 0;
    int               acc_cyc = 0;

    // Collector for the serial stream seen on x
    logic [31:0] bits;
    int          nbits;
    int          ndone;
    int          first_cyc;
    int          last_cyc;

    function automatic logic [31:0] frame_of(input logic [WIDTH-1:0] d);
`ifdef SER_PARITY_EN
        return {23'd0, d, ^d};
`else
        return {24'd0, d};
`endif
    endfunction

    task automatic model_reset();
        q_bit.delete();
        q_done.delete();
        hold_full_m = 1'b0;
        hold_m      = '0;
        ready_m     = 1'b0;
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] d);
        logic [31:0] f;
        f = frame_of(d);
        for (int i = FLEN - 1; i >= 0; i--) begin
            q_bit.push_back(f[i]);
            q_done.push_back(i == 0);
        end
    endtask

    task automatic clear_collect();
        bits      = '0;
        nbits     = 0;
        ndone     = 0;
        first_cyc = -1;
        last_cyc  = -1;
    endtask

    task automatic compare_outputs();
        bit ex_v;
        bit ex_x;
        bit ex_d;
        ex_v = (q_bit.size() > 0);
        ex_x = 1'b0;
        ex_d = 1'b0;
        if (ex_v) begin
            ex_x = q_bit[0];
            ex_d = q_done[0];
        end
        check_eq("x_valid", x_valid, ex_v);
        check_eq("x", x, ex_x);
        check_eq("frame_done", frame_done, ex_d);
        check_eq("busy", busy, ex_v || hold_full_m);
        check_eq("in_ready", in_ready, ready_m);
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare
    task automatic step();
        bit do_acc;
        @(posedge clk);
        acc_m = 1'b0;
        if (!reset) begin
            model_reset();
        end else begin
            do_acc = in_valid && ready_m;
            if (q_bit.size() > 0) begin
                void'(q_bit.pop_front());
                void'(q_done.pop_front());
            end
            if (q_bit.size() == 0 && hold_full_m) begin
                push_frame(hold_m);
                hold_full_m = 1'b0;
            end
            if (do_acc) begin
                hold_m      = in_data;
                hold_full_m = 1'b1;
                acc_m       = 1'b1;
            end
            ready_m = !hold_full_m;
        end
        cyc++;
        #1;
        compare_outputs();
        if (x_valid) begin
            bits = {bits[30:0], x};
            nbits++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        if (frame_done) ndone++;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc_m && n < 60);
        check_eq("send_accepted", acc_m, 1'b1);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || x_valid) && n < 100) begin
            step();
            n++;
        end
        check_eq("drain_busy", busy, 1'b0);
    endtask

    initial begin
        int n;
        int prob;
        model_reset();
        clear_collect();

        // Reset held two cycles, then released between edges
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        check_eq("rst_x", x, 1'b0);
        check_eq("rst_rdy_before_edge", in_ready, 1'b0);
        step();
        check_eq("rst_rdy_after_edge", in_ready, 1'b1);

        // Single word B4: MSB first, one cycle after the transfer edge
        clear_collect();
        send_word(8'hB4);
        drain();
`ifdef SER_PARITY_EN
        check_eq("b4_bits", bits, 32'h168);
`else
        check_eq("b4_bits", bits, 32'hB4);
`endif
        check_eq("b4_nbits", nbits, FLEN);
        check_eq("b4_latency", first_cyc - acc_cyc, 1);
        check_eq("b4_span", last_cyc - first_cyc + 1, FLEN);
        check_eq("b4_done", ndone, 1);

        // Word 01 (parity 1 when enabled)
        clear_collect();
        send_word(8'h01);
        drain();
`ifdef SER_PARITY_EN
        check_eq("w01_bits", bits, 32'h003);
`else
        check_eq("w01_bits", bits, 32'h01);
`endif
        check_eq("w01_done", ndone, 1);

        // Back-to-back: no gap between frames
        clear_collect();
        send_word(8'hB4);
        send_word(8'h5A);
        drain();
        check_eq("b2b_bits", bits, (frame_of(8'hB4) << FLEN) | frame_of(8'h5A));
        check_eq("b2b_nbits", nbits, 2 * FLEN);
        check_eq("b2b_span", last_cyc - first_cyc + 1, 2 * FLEN);
        check_eq("b2b_done", ndone, 2);

        // Backpressure: FF offered while holding is full waits, no loss or duplication
        clear_collect();
        send_word(8'hB4);
        send_word(8'h5A);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        #1;
        check_eq("bp_ready_low", in_ready, 1'b0);
        send_word(8'hFF);
        drain();
        check_eq("bp_nbits", nbits, 3 * FLEN);
        check_eq("bp_last", bits & ((32'd1 << FLEN) - 1), frame_of(8'hFF));
        check_eq("bp_done", ndone, 3);

        // Reset mid-frame after three bits
        clear_collect();
        send_word(8'hB4);
        n = 0;
        while (nbits < 3 && n < 40) begin
            step();
            n++;
        end
        check_eq("mid_bits_seen", nbits, 3);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_x_valid", x_valid, 1'b0);
        check_eq("mid_x", x, 1'b0);
        check_eq("mid_busy", busy, 1'b0);
        check_eq("mid_done", frame_done, 1'b0);
        check_eq("mid_ready", in_ready, 1'b0);
        model_reset();
        clear_collect();
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check_eq("mid_no_done", ndone, 0);
        check_eq("mid_no_bits", nbits, 0);

        // Randomized traffic at three offered loads
        for (int i = 0; i < 3000; i++) begin
            prob = (i < 1000) ? 20 : ((i < 2000) ? 70 : 100);
            in_valid = ($urandom_range(0, 99) < prob);
            in_data  = WIDTH'($urandom);
            step();
        end
        in_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per frame; legal range 2..32.
REQ-002 Parameter IDLE_VAL, default 1'b0, level driven on x when no bit is valid.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; low clears all state immediately, regardless of clk.
REQ-005 Port in_data  input  WIDTH  parallel word to serialize.
REQ-006 Port in_valid  input  1  in_data is valid this cycle.
REQ-007 Port in_ready  output  1  holding register is empty; a word can be accepted.
REQ-008 Port x  output  1  serial bit stream, MSB first, feeding the downstream Mealy detector's x input.
REQ-009 Port x_valid  output  1  x carries a frame bit this cycle.
REQ-010 Port busy  output  1  a frame is being shifted, or a word is held.
REQ-011 Port frame_done  output  1  one-cycle pulse coinciding with the last bit of a frame.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 A word SHALL be accepted at a rising edge where in_valid=1 and in_ready=1; in_data is captured into a WIDTH-bit holding register, and in_ready goes 0 after that edge.
REQ-014 in_ready SHALL equal NOT(holding full); in_valid while in_ready=0 is ignored and causes no state change.
REQ-015 The state machine SHALL have states IDLE, SHIFT and, with SER_PARITY_EN only, PARITY.
REQ-016 IDLE: x=IDLE_VAL, x_valid=0. If holding is full, the next edge moves it into the shift register, empties holding, sets the bit counter to WIDTH-1 and enters SHIFT.
REQ-017 SHIFT: x = shift-register MSB, x_valid=1. Each edge shifts left by one and decrements the counter.
REQ-018 Latency: a word accepted at edge E SHALL drive its bit i (i=0 is the MSB) on x during the cycle after edge E+1+i.
REQ-019 On the last data bit (counter=0), frame_done SHALL be 1 unless PARITY follows.
REQ-020 After the final frame bit, if holding is full, the next edge SHALL reload and stay in SHIFT; the next frame's MSB follows with zero gap cycles. Otherwise the machine returns to IDLE.
REQ-021 Holding empties at every frame start, so one word per WIDTH cycles SHALL sustain a continuous stream.
REQ-022 busy SHALL be 1 whenever the state is not IDLE or holding is full.
REQ-023 Acceptance and holding-to-shift transfer cannot coincide, because in_ready=0 while holding is full; the design SHALL not rely on resolving them simultaneously.

Reset
REQ-024 When reset=0: state=IDLE, holding empty, shift register and counter zero, x=IDLE_VAL, x_valid=0, in_ready=0, busy=0, frame_done=0.
REQ-025 in_ready SHALL rise to 1 on the first rising edge after reset returns to 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame and discard the held word; no frame_done is produced for the aborted frame.

Configuration
REQ-027 With macro SER_PARITY_EN defined, after the last data bit the machine SHALL enter PARITY for one cycle and then apply the REQ-020 rule.
- PARITY drives x = XOR of all WIDTH data bits (even parity) with x_valid=1 and frame_done=1.
- The frame is WIDTH+1 bits.
REQ-028 With SER_PARITY_EN undefined, the PARITY state and its logic SHALL be absent, and the frame is WIDTH bits.

Verification
REQ-029 Reset: hold reset=0 for 2 cycles, release -> x=0, x_valid=0, frame_done=0, busy=0; in_ready=1 after the first edge.
REQ-030 Single word 8'hB4 accepted at edge E -> x=1,0,1,1,0,1,0,0 after edges E+1..E+8; x_valid=1 for exactly those 8 cycles; frame_done only in the cycle of the final 0. The downstream Mealy detector sees the input sequence 1,0,1,1,0,1.
REQ-031 Back-to-back: 8'hB4, then 8'h5A offered with in_valid held high -> 16 contiguous valid bits 10110100 01011010, no x_valid gap, frame_done pulses twice.
REQ-032 Backpressure: in_valid=1 with 8'hFF while holding is full -> in_ready=0 and the word is not accepted until holding empties; no data lost or duplicated.
REQ-033 Reset mid-frame: assert reset after 3 bits of 8'hB4 -> x_valid=0 and x=0 immediately; after release, the machine is IDLE and no frame_done occurs.
REQ-034 SER_PARITY_EN: 8'h01 -> 9 bits 00000001 then parity 1, frame_done on bit 9; 8'hB4 -> parity bit 0.
